// File: rtl/pipelined_wallace_mult_if.sv
// rtl/pipelined_wallace_mult_if.sv - operand/result stream bundle for pipelined_wallace_mult
// master drives operands and out_ready; slave is the multiplier.
interface pipelined_wallace_mult_if #(
  parameter int WIDTH = 24,
  parameter int TAG_W = 4
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_a;
  logic [WIDTH-1:0]     in_b;
  logic                 in_signed;
  logic [TAG_W-1:0]     in_tag;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   out_prod;
  logic [TAG_W-1:0]     out_tag;

  modport master (
    output in_valid, in_a, in_b, in_signed, in_tag, out_ready,
    input  in_ready, out_valid, out_prod, out_tag
  );

  modport slave (
    input  in_valid, in_a, in_b, in_signed, in_tag, out_ready,
    output in_ready, out_valid, out_prod, out_tag
  );
endinterface

// File: rtl/pipelined_wallace_mult.sv
// rtl/pipelined_wallace_mult.sv - three-stage Wallace-tree multiplier, per-beat signed/unsigned
// S1 registers operands, S2 registers the carry-save rows, S3 registers the final sum.
module pipelined_wallace_mult #(
  parameter int WIDTH = 24,
  parameter int TAG_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pipelined_wallace_mult_if.slave bus
);
  localparam int PW = 2 * WIDTH;
  localparam int NR = WIDTH + 1;

  // Baugh-Wooley rows (NAND terms on the sign row/column plus a constant row),
  // then 3:2 carry-save levels until two rows remain.
  function automatic logic [2*PW-1:0] wallace_rows(input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b,
                                                   input logic             sgn);
    logic [PW-1:0] row [NR];
    logic [PW-1:0] nxt [NR];
    logic          p;
    int            n;
    int            m;
    for (int i = 0; i < WIDTH; i++) begin
      row[i] = '0;
      for (int j = 0; j < WIDTH; j++) begin
        p = a[j] & b[i];
        if (sgn && ((i == WIDTH - 1) != (j == WIDTH - 1))) p = ~p;
        row[i][i+j] = p;
      end
    end
    row[WIDTH] = '0;
    if (sgn) begin
      row[WIDTH][WIDTH] = 1'b1;
      row[WIDTH][PW-1]  = 1'b1;
    end
    n = NR;
    for (int lvl = 0; lvl < NR; lvl++) begin
      if (n > 2) begin
        m = 0;
        for (int k = 0; k < NR; k++) nxt[k] = '0;
        for (int g = 0; g < NR / 3; g++) begin
          if (3 * g + 2 < n) begin
            nxt[m]   = row[3*g] ^ row[3*g+1] ^ row[3*g+2];
            nxt[m+1] = ((row[3*g] & row[3*g+1]) | (row[3*g] & row[3*g+2]) |
                        (row[3*g+1] & row[3*g+2])) << 1;
            m = m + 2;
          end
        end
        for (int k = 0; k < NR; k++) begin
          if (k >= (n / 3) * 3 && k < n) begin
            nxt[m] = row[k];
            m = m + 1;
          end
        end
        row = nxt;
        n   = m;
      end
    end
    return {row[0], row[1]};
  endfunction

  logic                 w_advance;
  logic [2*PW-1:0]      w_tree;

  logic                 r1_valid;
  logic [WIDTH-1:0]     r1_a;
  logic [WIDTH-1:0]     r1_b;
  logic                 r1_signed;
  logic [TAG_W-1:0]     r1_tag;

  logic                 r2_valid;
  logic [PW-1:0]        r2_sum;
  logic [PW-1:0]        r2_carry;
  logic [TAG_W-1:0]     r2_tag;

  logic                 r_out_valid;
  logic [PW-1:0]        r_out_prod;
  logic [TAG_W-1:0]     r_out_tag;

  assign w_advance     = !r_out_valid || bus.out_ready;
  assign w_tree        = wallace_rows(r1_a, r1_b, r1_signed);

  assign bus.in_ready  = w_advance;
  assign bus.out_valid = r_out_valid;
  assign bus.out_prod  = r_out_prod;
  assign bus.out_tag   = r_out_tag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1_valid    <= 1'b0;
      r1_a        <= '0;
      r1_b        <= '0;
      r1_signed   <= 1'b0;
      r1_tag      <= '0;
      r2_valid    <= 1'b0;
      r2_sum      <= '0;
      r2_carry    <= '0;
      r2_tag      <= '0;
      r_out_valid <= 1'b0;
      r_out_prod  <= '0;
      r_out_tag   <= '0;
    end else if (w_advance) begin
      r1_valid    <= bus.in_valid;
      r1_a        <= bus.in_a;
      r1_b        <= bus.in_b;
      r1_signed   <= bus.in_signed;
      r1_tag      <= bus.in_tag;
      r2_valid    <= r1_valid;
      r2_sum      <= w_tree[2*PW-1:PW];
      r2_carry    <= w_tree[PW-1:0];
      r2_tag      <= r1_tag;
      r_out_valid <= r2_valid;
      r_out_prod  <= r2_sum + r2_carry;
      r_out_tag   <= r2_tag;
    end
  end
endmodule
